// File: rtl/rat_reduce.sv
// Reduces an unsigned rational num/den to lowest terms: binary GCD, then two
// parallel restoring dividers divide both terms by the GCD.
module rat_reduce #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_err
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, GCD, DIV, DONE} state_t;

    state_t                     state_reg;
    logic [WIDTH-1:0]           a_reg;
    logic [WIDTH-1:0]           b_reg;
    logic [KW-1:0]              k_reg;
    logic [WIDTH-1:0]           g_reg;
    logic [KW-1:0]              cnt_reg;
    logic [1:0][WIDTH-1:0]      q_reg;
    logic [1:0][WIDTH-1:0]      r_reg;
    logic                       in_ready_reg;
    logic                       out_valid_reg;
    logic [WIDTH-1:0]           out_num_reg;
    logic [WIDTH-1:0]           out_den_reg;
    logic                       out_err_reg;

    logic [1:0][WIDTH:0]        r_shift;
    logic [1:0]                 fit;
    logic [1:0][WIDTH-1:0]      r_next;
    logic [1:0][WIDTH-1:0]      q_next;

    // Divider 0 handles the numerator, divider 1 the denominator. The dividend
    // register doubles as the quotient register: quotient bits shift in at the LSB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_div
            assign r_shift[gi] = {r_reg[gi], q_reg[gi][WIDTH-1]};
            assign fit[gi]     = (r_shift[gi] >= {1'b0, g_reg});
            assign r_next[gi]  = fit[gi] ? (r_shift[gi][WIDTH-1:0] - g_reg)
                                         : r_shift[gi][WIDTH-1:0];
            assign q_next[gi]  = {q_reg[gi][WIDTH-2:0], fit[gi]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            k_reg         <= '0;
            g_reg         <= '0;
            cnt_reg       <= '0;
            q_reg         <= '0;
            r_reg         <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_num_reg   <= '0;
            out_den_reg   <= '0;
            out_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        in_ready_reg <= 1'b0;
                        if (in_den == '0) begin
                            out_num_reg <= '0;
                            out_den_reg <= '0;
                            out_err_reg <= 1'b1;
                            state_reg   <= DONE;
                        end else if (in_num == '0) begin
                            out_num_reg <= '0;
                            out_den_reg <= WIDTH'(1);
                            out_err_reg <= 1'b0;
                            state_reg   <= DONE;
                        end else begin
                            a_reg     <= in_num;
                            b_reg     <= in_den;
                            k_reg     <= '0;
                            q_reg     <= {in_den, in_num};
                            r_reg     <= '0;
                            state_reg <= GCD;
                        end
                    end
                end
                GCD: begin
                    if (a_reg == b_reg) begin
                        g_reg     <= a_reg << k_reg;
                        cnt_reg   <= '0;
                        state_reg <= DIV;
                    end else if (!a_reg[0] && !b_reg[0]) begin
                        a_reg <= a_reg >> 1;
                        b_reg <= b_reg >> 1;
                        k_reg <= k_reg + 1'b1;
                    end else if (!a_reg[0]) begin
                        a_reg <= a_reg >> 1;
                    end else if (!b_reg[0]) begin
                        b_reg <= b_reg >> 1;
                    end else if (a_reg > b_reg) begin
                        a_reg <= (a_reg - b_reg) >> 1;
                    end else begin
                        b_reg <= (b_reg - a_reg) >> 1;
                    end
                end
                DIV: begin
                    q_reg   <= q_next;
                    r_reg   <= r_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == KW'(WIDTH - 1)) begin
                        out_num_reg   <= q_next[0];
                        out_den_reg   <= q_next[1];
                        out_err_reg   <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // Bypass results arrive with out_valid low; raise it one cycle later.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_num   = out_num_reg;
    assign out_den   = out_den_reg;
    assign out_err   = out_err_reg;

endmodule

// File: tb/tb_rat_reduce.sv
// Bench for rat_reduce: directed 8-bit vectors and corner sequences, plus a
// randomized 16-bit run checked against a Euclid-based reference.
module tb_rat_reduce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, oe8;
    logic [7:0] in8, id8, on8, od8;
    logic        iv16, ir16, ov16, or16, oe16;
    logic [15:0] in16, id16, on16, od16;

    rat_reduce #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_num(in8), .in_den(id8),
        .out_valid(ov8), .out_ready(or8), .out_num(on8), .out_den(od8), .out_err(oe8)
    );

    rat_reduce #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_num(in16), .in_den(id16),
        .out_valid(ov16), .out_ready(or16), .out_num(on16), .out_den(od16), .out_err(oe16)
    );

    typedef struct {
        int num; int den; int en; int ed; int ee; int lat;
    } vec_t;

    typedef struct {
        int unsigned n; int unsigned d; int e; int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   spurious = 0;
    logic busy16 = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int unsigned gcd_ref(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (!rst && ov16 && !busy16) spurious++;
    end

    task automatic wait_ready8();
        int n = 0;
        @(negedge clk);
        while (!ir8 && n < 5) begin
            @(negedge clk);
            n++;
        end
        if (!ir8) chk("ready8_timeout", 0, 1);
    endtask

    // One full 8-bit transaction with out_ready held high.
    task automatic run8(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        wait_ready8();
        in8 = 8'(v.num);
        id8 = 8'(v.den);
        iv8 = 1'b1;
        e.n = v.en; e.d = v.ed; e.e = v.ee; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk); #1;
        iv8 = 1'b0;
        in8 = 8'($urandom);
        id8 = 8'($urandom);
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov8) begin
            chk("out_valid8_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        chk("num8", on8, got.n);
        chk("den8", od8, got.d);
        chk("err8", oe8, got.e);
        chk("lat8", lat, got.lat);
        chk("busy_in_ready8", ir8, 0);
        @(posedge clk); #1;
        chk("valid_clear8", ov8, 0);
        chk("in_ready_back8", ir8, 1);
        $display("txn w8 %0d/%0d -> %0d/%0d err=%0d lat=%0d", v.num, v.den, on8, od8, oe8, lat);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t bp;
        int   lat;
        int   seen;
        iv8 = 0; in8 = 0; id8 = 0; or8 = 1;
        iv16 = 0; in16 = 0; id16 = 0; or16 = 1;

        tbl[0] = '{6, 4, 3, 2, 0, 12};
        tbl[1] = '{255, 255, 1, 1, 0, 9};
        tbl[2] = '{13, 8, 13, 8, 0, 15};
        tbl[3] = '{0, 5, 0, 1, 0, 1};
        tbl[4] = '{7, 0, 0, 0, 1, 1};
        tbl[5] = '{0, 0, 0, 0, 1, 1};
        tbl[6] = '{9, 6, 3, 2, 0, 11};
        tbl[7] = '{128, 2, 64, 1, 0, 16};
        tbl[8] = '{255, 1, 255, 1, 0, 16};
        tbl[9] = '{1, 1, 1, 1, 0, 9};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ov8, 0);
        chk("rst_num", on8, 0);
        chk("rst_den", od8, 0);
        chk("rst_err", oe8, 0);
        chk("rst_in_ready", ir8, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run8(tbl[i]);

        // Backpressure: result held while out_ready is low, new requests refused.
        wait_ready8();
        or8 = 1'b0;
        in8 = 8'd6; id8 = 8'd4; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, 12);
        iv8 = 1'b1; in8 = 8'd2; id8 = 8'd2;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", ov8, 1);
            chk("bp_num", on8, 3);
            chk("bp_den", od8, 2);
            chk("bp_in_ready", ir8, 0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", ov8, 0);
        chk("bp_release_ready", ir8, 1);
        $display("txn w8 6/4 backpressure -> 3/2 lat=%0d", lat);

        // Asynchronous reset in the middle of DIV for 200/120.
        wait_ready8();
        in8 = 8'd200; id8 = 8'd120; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", ov8, 0);
        chk("abort_num", on8, 0);
        chk("abort_den", od8, 0);
        chk("abort_err", oe8, 0);
        chk("abort_in_ready", ir8, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (ov8) seen++;
        end
        chk("abort_no_result", seen, 0);
        $display("txn w8 200/120 aborted by reset");
        bp = '{200, 120, 5, 3, 0, 14};
        run8(bp);

        // Randomized 16-bit run.
        for (int t = 0; t < 1000; t++) begin
            int unsigned n, d, g, x, y, g0;
            int          sel, wt;
            exp_t        e, got;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                n = 0; d = $urandom_range(0, 65535);
            end else if (sel == 1) begin
                n = $urandom_range(0, 65535); d = 0;
            end else if (sel[0]) begin
                n = $urandom_range(1, 65535); d = $urandom_range(1, 65535);
            end else begin
                g0 = $urandom_range(1, 255);
                x  = $urandom_range(1, 255);
                y  = $urandom_range(1, 255);
                n  = x * g0; d = y * g0;
            end
            if (d == 0) begin
                e.n = 0; e.d = 0; e.e = 1;
            end else if (n == 0) begin
                e.n = 0; e.d = 1; e.e = 0;
            end else begin
                g = gcd_ref(n, d);
                e.n = n / g; e.d = d / g; e.e = 0;
            end
            e.lat = (n == 0 || d == 0) ? 1 : 0;
            wt = 0;
            @(negedge clk);
            while (!ir16 && wt < 5) begin
                @(negedge clk);
                wt++;
            end
            in16 = 16'(n); id16 = 16'(d); iv16 = 1'b1;
            sb.push_back(e);
            @(posedge clk); #1;
            busy16 = 1'b1;
            iv16 = 1'b0;
            in16 = 16'($urandom); id16 = 16'($urandom);
            lat = 0;
            while (!ov16 && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            got = sb.pop_front();
            if (!ov16) begin
                chk("out_valid16_timeout", 0, 1);
                busy16 = 1'b0;
                continue;
            end
            chk("num16", on16, got.n);
            chk("den16", od16, got.d);
            chk("err16", oe16, got.e);
            if (got.lat == 1) begin
                chk("lat16_bypass", lat, 1);
            end else begin
                chk("lat16_range", (lat >= 17 && lat <= 48) ? 1 : 0, 1);
                chk("coprime16", gcd_ref(on16, od16), 1);
            end
            @(posedge clk); #1;
            busy16 = 1'b0;
            $display("txn w16 %0d/%0d -> %0d/%0d err=%0d lat=%0d", n, d, on16, od16, oe16, lat);
        end

        chk("spurious_out_valid16", spurious, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rat_reduce.md
# rat_reduce

Normalizing stage placed directly downstream of the rational divide and multiply stages. Takes an unreduced unsigned rational (num, den) and returns it in lowest terms: binary (Stein) GCD, then both terms divided by the GCD with a pair of serial restoring dividers. Zero-numerator and zero-denominator inputs take a single-cycle bypass, and a zero denominator raises an error flag. Valid/ready handshakes on both sides let the block absorb the variable latency.

## Interface
- WIDTH, 32, bit width of every numerator/denominator term (unsigned)
- clk  input  1  rising-edge clock; only clock in the block
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents in_num/in_den
- in_ready  output  1  block can accept; high only in IDLE
- in_num  input  WIDTH  unreduced numerator
- in_den  input  WIDTH  unreduced denominator
- out_valid  output  1  out_num/out_den/out_err valid
- out_ready  input  1  downstream accepts result
- out_num  output  WIDTH  reduced numerator
- out_den  output  WIDTH  reduced denominator
- out_err  output  1  high when the input denominator was zero

## Operation
- States: IDLE, GCD, DIV, DONE. Reset forces IDLE. All outputs are registered and reset to 0.
- IDLE: in_ready=1. Accept when in_valid && in_ready; capture num and den.
  - If den==0: go to DONE with out_num=0, out_den=0, out_err=1.
  - Else if num==0: go to DONE with out_num=0, out_den=1, out_err=0.
  - Else: a=num, b=den, k=0; go to GCD.
- GCD, one step per cycle, priority order:
  - a==b: g=a<<k; go to DIV.
  - a, b both even: a>>=1, b>>=1, k+=1.
  - Only a even: a>>=1.
  - Only b even: b>>=1.
  - Both odd, a>b: a=(a-b)>>1.
  - Both odd, otherwise: b=(b-a)>>1.
  - a and b never become 0. k never exceeds WIDTH-1. g fits in WIDTH bits.
- DIV: two restoring dividers run in parallel, num/g and den/g, 1 quotient bit per cycle, MSB first.
  - Exactly WIDTH cycles, then go to DONE.
  - Remainders are discarded; they are exact zero by construction.
- DONE: out_valid=1; out_num, out_den and out_err held stable.
  - On out_valid && out_ready: go to IDLE and clear out_valid on the same edge.
- Nonzero results always have gcd(out_num, out_den)=1.
- Inputs are sampled only at the accept edge. in_num and in_den may change freely afterwards.
- rst asserted in any state, including mid-GCD or mid-DIV: immediately IDLE, all outputs 0, in-flight operand discarded, no partial result emitted.

## Timing
- Accept edge = edge 0.
- Bypass (num==0 or den==0): out_valid high after edge 1. Latency 1.
- Normal path:
  - G = number of cycles spent in GCD, including the a==b cycle. G ranges from 1 to 2·WIDTH.
  - State is DIV after edge G. out_valid is high after edge G+WIDTH. Latency G+WIDTH.
- in_ready is 0 from the accept edge until the edge that takes DONE back to IDLE.
- in_ready goes high the cycle after the output handshake. The block does not overlap operations, so minimum spacing between accepts is latency+1 cycles.
- out_ready held low: DONE persists indefinitely with outputs unchanged. out_ready high at entry to DONE: one cycle of out_valid.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

## Test plan
- WIDTH=8, in 6/4 → GCD takes 4 cycles (g=2); out 3/2, out_err=0; out_valid after edge 12 with out_ready=1; in_ready high again after edge 13.
- WIDTH=8, in 255/255 → G=1 (g=255); out 1/1 after edge 9. In 13/8 → out 13/8 (coprime, g=1).
- WIDTH=8, in 0/5 → out 0/1, err=0 after edge 1. In 7/0 → out 0/0, err=1 after edge 1. In 0/0 → out 0/0, err=1.
- Backpressure: 6/4 with out_ready=0 for 5 cycles after out_valid → out_num=3, out_den=2, out_valid=1 stable throughout; in_ready=0 throughout; a second in_valid during this window is not accepted.
- Reset abort: assert rst asynchronously (mid-cycle) during DIV of 200/120 → state IDLE, outputs 0 with no clock edge needed. After release, 200/120 → out 5/3.
- Randomized: 1000 operand pairs with WIDTH=16 against a reference gcd model; check exact values, gcd(out)=1, latency within [1+WIDTH, 3·WIDTH], and no out_valid without a prior accept.
